// File: rtl/disp_value_bcd.sv
// disp_value_bcd: debounced selection of one of eight debug sources and a
// sequential conversion of the chosen value into four display digits
// (double-dabble decimal or straight hex nibbles).
module disp_value_bcd #(
  parameter int W              = 16,
  parameter int DEB_CYCLES     = 250000,
  parameter int REFRESH_CYCLES = 2500000
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [2:0]     sw,
  input  logic           hex_mode,
  input  logic [8*W-1:0] src_bus,
  output logic [15:0]    digits,
  output logic           digits_valid,
  output logic           ovf,
  output logic [2:0]     sel_stable,
  output logic           busy
);

  localparam int DEB_W = $clog2(DEB_CYCLES + 1);
  localparam int REF_W = $clog2(REFRESH_CYCLES + 1);
  localparam int CNT_W = $clog2(W + 1);

  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
  localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);
  localparam logic [W-1:0]     DEC_MAX  = W'(9999);

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  // Add 3 to every BCD digit that is 5 or more, ahead of the doubling shift.
  function automatic logic [19:0] dd_adjust(input logic [19:0] b);
    logic [19:0] a;
    a = b;
    for (int i = 0; i < 5; i++) begin
      if (a[4*i +: 4] >= 4'd5) a[4*i +: 4] = a[4*i +: 4] + 4'd3;
    end
    return a;
  endfunction

  // Clamp a decimal result that did not fit four digits to all nines.
  function automatic logic [15:0] sat_digits(input logic [15:0] b, input logic over);
    return over ? 16'h9999 : b;
  endfunction

  logic [2:0]       sw_p0;
  logic [2:0]       sw_p1;
  logic [2:0]       sw_prev;
  logic [DEB_W-1:0] deb_cnt;
  logic [REF_W-1:0] ref_cnt;
  logic             req_p0;
  logic             pending;
  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [W-1:0]     bin;
  logic [19:0]      bcd;
  logic             hex_cap;
  logic             ovf_cap;

  logic             sw_changed;
  logic             sw_fire;
  logic             ref_wrap;
  logic [W-1:0]     src_sel;
  logic [19:0]      bcd_adj;

  assign sw_changed = (sw_p1 != sw_prev);
  // A change is accepted only after sw_p1 has held the same value long enough.
  assign sw_fire    = !sw_changed && (deb_cnt == DEB_LAST) && (sw_p1 != sel_stable);
  assign ref_wrap   = (ref_cnt == REF_LAST);
  assign bcd_adj    = dd_adjust(bcd);

  // Source multiplexer driven by the debounced select.
  always_comb begin
    src_sel = '0;
    for (int k = 0; k < 8; k++) begin
      if (sel_stable == 3'(k)) src_sel = src_bus[k*W +: W];
    end
  end

  // Synchronise the switches, debounce them and update the select in use.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sw_p0      <= '0;
      sw_p1      <= '0;
      sw_prev    <= '0;
      deb_cnt    <= '0;
      sel_stable <= '0;
    end else begin
      // stage p0 -> p1: two-flop synchroniser
      sw_p0   <= sw;
      sw_p1   <= sw_p0;
      sw_prev <= sw_p1;
      if (sw_changed)
        deb_cnt <= '0;
      else if (deb_cnt != DEB_LAST)
        deb_cnt <= deb_cnt + DEB_W'(1);
      if (sw_fire) sel_stable <= sw_p1;
    end
  end

  // Refresh timer and the registered capture request; the request is taken
  // one cycle late so the capture sees the freshly loaded sel_stable.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ref_cnt <= '0;
      req_p0  <= 1'b0;
    end else begin
      if (sw_fire || ref_wrap)
        ref_cnt <= '0;
      else
        ref_cnt <= ref_cnt + REF_W'(1);
      req_p0 <= sw_fire || ref_wrap;
    end
  end

  // Capture / convert / publish sequencer with registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      pending      <= 1'b0;
      cnt          <= '0;
      bin          <= '0;
      bcd          <= '0;
      hex_cap      <= 1'b0;
      ovf_cap      <= 1'b0;
      digits       <= '0;
      digits_valid <= 1'b0;
      ovf          <= 1'b0;
      busy         <= 1'b0;
    end else begin
      digits_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_p0 || pending) begin
            bin     <= src_sel;
            hex_cap <= hex_mode;
            ovf_cap <= (src_sel > DEC_MAX);
            bcd     <= '0;
            cnt     <= '0;
            pending <= 1'b0;
            busy    <= 1'b1;
            state   <= CONV;
          end
        end
        CONV: begin
          if (req_p0) pending <= 1'b1;
          // Hex keeps the captured word intact; the cycle count is shared so
          // both modes publish with the same latency.
          if (!hex_cap) {bcd, bin} <= {bcd_adj, bin} << 1;
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_LAST) state <= DONE;
        end
        DONE: begin
          if (req_p0) pending <= 1'b1;
          digits       <= hex_cap ? bin : sat_digits(bcd[15:0], ovf_cap);
          ovf          <= !hex_cap && ovf_cap;
          digits_valid <= 1'b1;
          busy         <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
